// File: rtl/viterbi_pkg.sv
// Shared constants and FSM state type for the Viterbi input shifter control path.
package viterbi_pkg;

    localparam int unsigned VIT_LANES  = 8;
    localparam int unsigned VIT_SYM_W  = 2;
    localparam int unsigned VIT_WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vit_state_e;

endpackage

// File: rtl/vit_lane_tracker.sv
// Phase counter and lane-valid shift register; both advance only on adv_i so the
// shifter's writes and skewed reads stay aligned across stalls.
module vit_lane_tracker
    import viterbi_pkg::*;
#(
    parameter int unsigned LANES = VIT_LANES,
    parameter int unsigned PH_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             wr_en_i,
    output logic [PH_W-1:0]  phase_o,
    output logic [LANES-1:0] lane_vld_o
);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [LANES-1:0] lane_vld_q, lane_vld_d;

    always_comb begin
        phase_d    = phase_q;
        lane_vld_d = lane_vld_q;
        if (adv_i) begin
            phase_d    = (phase_q == PH_W'(LANES - 1)) ? '0 : phase_q + 1'b1;
            lane_vld_d = {lane_vld_q[LANES-2:0], wr_en_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= '0;
            lane_vld_q <= '0;
        end else begin
            phase_q    <= phase_d;
            lane_vld_q <= lane_vld_d;
        end
    end

    assign phase_o    = phase_q;
    assign lane_vld_o = lane_vld_q;

endmodule

// File: rtl/viterbi_input_sched.sv
// Flow controller and phase sequencer for the Viterbi input shifter: accepts words,
// drives the shared advance enable, drains the symbol skew and flags block completion.
module viterbi_input_sched
    import viterbi_pkg::*;
#(
    parameter int unsigned LANES = VIT_LANES,
    parameter int unsigned PH_W  = 3,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             adv,
    output logic             wr_en,
    output logic [PH_W-1:0]  phase,
    output logic [LANES-1:0] lane_vld,
    output logic             busy,
    output logic             frame_done,
    output logic [LEN_W-1:0] word_cnt
);

    vit_state_e       state_q, state_d;
    logic [PH_W-1:0]  drain_q, drain_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    always_comb begin
        in_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
        accept   = in_valid && in_ready;
        adv      = accept || (state_q == ST_DRAIN);
        wr_en    = accept;
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = LEN_W'(1);
                    state_d = in_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (in_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Load on entry so DRAIN spans exactly LANES advances, whether entered from IDLE or RUN.
        if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) drain_d = PH_W'(LANES - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    vit_lane_tracker #(
        .LANES (LANES),
        .PH_W  (PH_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (adv),
        .wr_en_i    (wr_en),
        .phase_o    (phase),
        .lane_vld_o (lane_vld)
    );

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_viterbi_input_sched.sv
// Self-checking bench: directed tables, stall/wrap/back-to-back/reset sequences and
// randomized traffic against an advance-history reference model with a shifter scoreboard.
module tb_viterbi_input_sched;

    localparam int LANES = 8;
    localparam int PH_W  = 3;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready, adv, wr_en, busy, frame_done;
    logic [PH_W-1:0]  phase;
    logic [LANES-1:0] lane_vld;
    logic [LEN_W-1:0] word_cnt;

    always #5 clk = ~clk;

    viterbi_input_sched #(
        .LANES (LANES),
        .PH_W  (PH_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .adv        (adv),
        .wr_en      (wr_en),
        .phase      (phase),
        .lane_vld   (lane_vld),
        .busy       (busy),
        .frame_done (frame_done),
        .word_cnt   (word_cnt)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: history of advances (newest first), block bookkeeping.
    typedef struct {
        bit          wr;
        logic [15:0] data;
    } ev_t;
    ev_t         hist[$];
    int          adv_count  = 0;
    int          drain_left = 0;
    bit          done_now   = 0;
    bit          in_block   = 0;
    int          wcnt       = 0;
    logic [15:0] mem [LANES];
    bit          s_ready, s_adv;

    typedef struct {
        bit          v;
        bit          l;
        bit          ready;
        bit          adv;
        logic [7:0]  lv;
        bit          fd;
        logic [15:0] wc;
    } row_t;
    row_t t1[18];
    row_t t2[11];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic row_t mk(bit v, bit l, bit r, bit a, logic [7:0] lv, bit fd, logic [15:0] wc);
        row_t x;
        x.v = v; x.l = l; x.ready = r; x.adv = a; x.lv = lv; x.fd = fd; x.wc = wc;
        return x;
    endfunction

    function automatic void model_reset();
        hist.delete();
        adv_count  = 0;
        drain_left = 0;
        done_now   = 0;
        in_block   = 0;
        wcnt       = 0;
    endfunction

    task automatic check_regs();
        logic [7:0]  exp_lv;
        logic [15:0] word_act, word_exp;
        int          idx;
        exp_lv = '0;
        for (int k = 0; k < LANES; k++)
            if (k < hist.size() && hist[k].wr) exp_lv[k] = 1'b1;
        check("phase", phase, adv_count % LANES);
        check("lane_vld", lane_vld, exp_lv);
        check("busy", busy, in_block || (drain_left > 0) || done_now);
        check("frame_done", frame_done, done_now);
        check("word_cnt", word_cnt, wcnt);
        for (int k = 0; k < LANES; k++) begin
            if (exp_lv[k]) begin
                idx      = (int'(phase) + 2 * LANES - 1 - k) % LANES;
                word_act = mem[idx];
                word_exp = hist[k].data;
                check($sformatf("lane%0d_sym", k), word_act[2*k +: 2], word_exp[2*k +: 2]);
            end
        end
    endtask

    task automatic step(input bit v, input bit l);
        logic [15:0]     d;
        bit              exp_ready, acc, exp_adv, cap_wr, nd;
        logic [PH_W-1:0] cap_ph;
        d = 16'($urandom);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        #1;
        exp_ready = (drain_left == 0) && !done_now;
        acc       = v && exp_ready;
        exp_adv   = acc || (drain_left > 0);
        check("in_ready", in_ready, exp_ready);
        check("adv", adv, exp_adv);
        check("wr_en", wr_en, acc);
        s_ready = in_ready;
        s_adv   = adv;
        cap_wr  = wr_en;
        cap_ph  = phase;
        @(posedge clk);
        if (cap_wr) mem[cap_ph] = d;
        if (exp_adv) begin
            hist.push_front('{acc, d});
            if (hist.size() > LANES) void'(hist.pop_back());
            adv_count++;
        end
        nd = (drain_left == 1);
        if (drain_left > 0) drain_left--;
        else if (acc && l)  drain_left = LANES;
        done_now = nd;
        if (acc) begin
            wcnt     = in_block ? ((wcnt < 65535) ? wcnt + 1 : wcnt) : 1;
            in_block = !l;
        end
        #1;
        check_regs();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_adv", adv, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_phase", phase, 0);
        check("rst_lane_vld", lane_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_word_cnt", word_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_table1();
        for (int i = 0; i < 18; i++) begin
            step(t1[i].v, t1[i].l);
            check($sformatf("t1[%0d].ready", i), s_ready, t1[i].ready);
            check($sformatf("t1[%0d].adv", i), s_adv, t1[i].adv);
            check($sformatf("t1[%0d].lane_vld", i), lane_vld, t1[i].lv);
            check($sformatf("t1[%0d].frame_done", i), frame_done, t1[i].fd);
            check($sformatf("t1[%0d].word_cnt", i), word_cnt, t1[i].wc);
        end
    endtask

    initial begin
        // Block of 8 back-to-back words.
        t1[0]  = mk(1, 0, 1, 1, 8'h01, 0, 1);
        t1[1]  = mk(1, 0, 1, 1, 8'h03, 0, 2);
        t1[2]  = mk(1, 0, 1, 1, 8'h07, 0, 3);
        t1[3]  = mk(1, 0, 1, 1, 8'h0F, 0, 4);
        t1[4]  = mk(1, 0, 1, 1, 8'h1F, 0, 5);
        t1[5]  = mk(1, 0, 1, 1, 8'h3F, 0, 6);
        t1[6]  = mk(1, 0, 1, 1, 8'h7F, 0, 7);
        t1[7]  = mk(1, 1, 1, 1, 8'hFF, 0, 8);
        t1[8]  = mk(0, 0, 0, 1, 8'hFE, 0, 8);
        t1[9]  = mk(0, 0, 0, 1, 8'hFC, 0, 8);
        t1[10] = mk(0, 0, 0, 1, 8'hF8, 0, 8);
        t1[11] = mk(0, 0, 0, 1, 8'hF0, 0, 8);
        t1[12] = mk(0, 0, 0, 1, 8'hE0, 0, 8);
        t1[13] = mk(0, 0, 0, 1, 8'hC0, 0, 8);
        t1[14] = mk(0, 0, 0, 1, 8'h80, 0, 8);
        t1[15] = mk(0, 0, 0, 1, 8'h00, 1, 8);
        t1[16] = mk(0, 0, 0, 0, 8'h00, 0, 8);
        t1[17] = mk(0, 0, 1, 0, 8'h00, 0, 8);
        // Single-word block.
        t2[0]  = mk(1, 1, 1, 1, 8'h01, 0, 1);
        t2[1]  = mk(0, 0, 0, 1, 8'h02, 0, 1);
        t2[2]  = mk(0, 0, 0, 1, 8'h04, 0, 1);
        t2[3]  = mk(0, 0, 0, 1, 8'h08, 0, 1);
        t2[4]  = mk(0, 0, 0, 1, 8'h10, 0, 1);
        t2[5]  = mk(0, 0, 0, 1, 8'h20, 0, 1);
        t2[6]  = mk(0, 0, 0, 1, 8'h40, 0, 1);
        t2[7]  = mk(0, 0, 0, 1, 8'h80, 0, 1);
        t2[8]  = mk(0, 0, 0, 1, 8'h00, 1, 1);
        t2[9]  = mk(0, 0, 0, 0, 8'h00, 0, 1);
        t2[10] = mk(0, 0, 1, 0, 8'h00, 0, 1);

        reset_mid();
        run_table1();

        for (int i = 0; i < 11; i++) begin
            step(t2[i].v, t2[i].l);
            check($sformatf("t2[%0d].ready", i), s_ready, t2[i].ready);
            check($sformatf("t2[%0d].adv", i), s_adv, t2[i].adv);
            check($sformatf("t2[%0d].lane_vld", i), lane_vld, t2[i].lv);
            check($sformatf("t2[%0d].frame_done", i), frame_done, t2[i].fd);
            check($sformatf("t2[%0d].word_cnt", i), word_cnt, t2[i].wc);
        end

        // Stall pattern 1,0,0,1,1; in_last alone is ignored during a gap.
        step(1, 0);
        step(0, 1);
        check("stall_gap1_adv", s_adv, 0);
        step(0, 0);
        check("stall_gap2_adv", s_adv, 0);
        step(1, 0);
        step(1, 1);
        for (int i = 0; i < 10; i++) step(0, 0);

        // Back-to-back blocks with in_valid held high.
        step(1, 0);
        step(1, 0);
        step(1, 1);
        for (int i = 0; i < 9; i++) begin
            step(1, 0);
            check($sformatf("b2b_blocked%0d", i), s_ready, 0);
        end
        step(1, 0);
        check("b2b_accept_ready", s_ready, 1);
        check("b2b_word_cnt", word_cnt, 1);
        step(1, 1);
        for (int i = 0; i < 10; i++) step(0, 0);

        // Reset in the middle of DRAIN, then a full block again.
        for (int i = 0; i < 3; i++) step(1, 0);
        step(1, 1);
        step(0, 0);
        step(0, 0);
        check("pre_rst_lane_vld", lane_vld, 8'h3C);
        reset_mid();
        run_table1();

        // 11-word block from phase 0, wrapping the phase.
        reset_mid();
        for (int i = 0; i < 11; i++) begin
            step(1, i == 10);
            if (i == 6) check("wrap_phase7", phase, 7);
            if (i == 7) check("wrap_phase0", phase, 0);
        end
        for (int i = 0; i < 10; i++) step(0, 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) reset_mid();
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
